mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between the pipelined core's fetch port (I) and data port (D).
//  Arbitrates, issues one transaction at a time with a req/gnt/rvalid handshake and returns responses.
//  Data has priority; a streak counter bounds fetch starvation, and a watchdog bounds memory latency.
//  Sits between the core's PCF/InstrF and ALUResultM/WriteDataM/ReadDataM ports and the memory model.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  STARVE_LIM  4   consecutive D grants allowed while i_req is pending (>=1)
//  TIMEOUT     64  max cycles in WAIT before error response; 0 = watchdog disabled
// PORTS
//  clk        in   1   clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  i_req      in   1   fetch request, level; held until i_rvalid
//  i_addr     in   AW  fetch address, stable while i_req
//  i_rvalid   out  1   fetch response pulse (1 cycle)
//  i_rdata    out  DW  fetch data, valid with i_rvalid
//  i_err      out  1   fetch timed out, valid with i_rvalid
//  d_req      in   1   data request, level; held until d_rvalid
//  d_we       in   1   1 = write, 0 = read
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_rvalid   out  1   data response pulse (1 cycle); read data or write ack
//  d_rdata    out  DW  read data; 0 for writes
//  d_err      out  1   data timed out, valid with d_rvalid
//  mem_req    out  1   memory request, held until mem_gnt
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_gnt    in   1   memory accepts request this cycle when mem_req=1
//  mem_rvalid in   1   memory response/ack for the accepted request (reads and writes)
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
//  - Reset (async, reset_n=0): state=IDLE; all outputs 0; streak and wait counters 0. Takes effect immediately, including mid-transaction.
//  - IDLE: if neither request is high, stay. Otherwise latch the winner (owner, we, addr, wdata) into the mem_* registers and go to ISSUE.
//    - Winner is D if d_req=1 and (i_req=0 or streak<STARVE_LIM); otherwise I.
//  - Streak counter: on a D grant with i_req=1, streak+=1 (saturating at STARVE_LIM). On an I grant, or a D grant with i_req=0, streak=0.
//  - ISSUE: mem_req=1 with fields held stable. On mem_gnt=1, go to WAIT and clear the wait counter. Otherwise stay in ISSUE (no timeout in ISSUE).
//  - WAIT: mem_req=0.
//    - mem_rvalid=1: capture mem_rdata into the owner's rdata (0 if we=1), err=0, go to RESP.
//    - Else, if TIMEOUT!=0 and wait count==TIMEOUT-1: rdata=0, err=1, go to RESP.
//    - Else wait count+=1.
//  - RESP: the owner's x_rvalid=1 for exactly this cycle; then go to IDLE. The requester drops or changes its request at the next edge.
//  - rdata/err hold their values after the pulse until the next response for that port.
//  - mem_rvalid outside WAIT is ignored. This covers stray responses after a timeout or a reset.
//  - Minimum access cost is 4 cycles (IDLE, ISSUE with gnt, WAIT with rvalid, RESP); no pipelining; one outstanding transaction.
//  - A request dropped before its rvalid is a protocol violation; the arbiter still completes and pulses rvalid.
// TESTING
//  1. I-only: i_req=1, i_addr=0x100 at cycle 0; mem_gnt at cycle 1; mem_rvalid=1, mem_rdata=0xDEADBEEF at cycle 3
//     -> mem_req=1/addr=0x100/we=0 at cycle 1; i_rvalid=1, i_rdata=0xDEADBEEF at cycle 4; d_rvalid stays 0.
//  2. i_req and d_req (read, 0x200) both rise in the same cycle, mem gnt immediate, latency 1
//     -> D is served first (mem_addr=0x200), then I (0x100); each port sees exactly one rvalid.
//  3. STARVE_LIM=2, d_req held high throughout, i_req held high
//     -> grant order D,D,I,D,D,I.
//  4. D write: d_we=1, addr 0x40, wdata 0x12345678
//     -> mem_we=1, mem_wdata=0x12345678; ack arrives -> d_rvalid=1, d_rdata=0, d_err=0.
//  5. TIMEOUT=8, D read granted, mem_rvalid never arrives
//     -> d_rvalid=1, d_err=1, d_rdata=0 after 8 WAIT cycles; a later stray mem_rvalid produces no rvalid.
//  6. reset_n=0 during WAIT
//     -> all outputs 0 in the same cycle; after release, a fresh I read completes normally and a stray mem_rvalid is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter sharing one single-port memory between fetch (I) and data (D) ports
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  // Streak counter must hold values 0..STARVE_LIM.
  localparam int SCW = $clog2(STARVE_LIM + 1);
  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SCW-1:0] STREAK_MAX = SCW'(STARVE_LIM);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t         state_q;
  logic           owner_d_q;     // 1 = current transaction belongs to the data port
  logic [SCW-1:0] streak_q;
  logic [WCW-1:0] wait_cnt_q;

  logic           mem_req_q;
  logic           mem_we_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;

  logic           i_rvalid_q;
  logic [DW-1:0]  i_rdata_q;
  logic           i_err_q;
  logic           d_rvalid_q;
  logic [DW-1:0]  d_rdata_q;
  logic           d_err_q;

  logic           d_wins;
  logic [SCW-1:0] streak_d;
  logic           resp_fire;
  logic [DW-1:0]  resp_rdata;
  logic           resp_err;

  // Arbitration: data wins unless a pending fetch has already been passed over STARVE_LIM times.
  always_comb begin
    d_wins   = d_req && (!i_req || (streak_q < STREAK_MAX));
    streak_d = '0;
    if (d_wins && i_req) begin
      streak_d = (streak_q < STREAK_MAX) ? (streak_q + 1'b1) : streak_q;
    end
  end

  // Response selection while waiting: real memory data first, otherwise watchdog expiry.
  always_comb begin
    resp_fire  = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (mem_rvalid) begin
      resp_fire  = 1'b1;
      resp_rdata = mem_we_q ? '0 : mem_rdata;
    end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
      resp_fire = 1'b1;
      resp_err  = 1'b1;
    end
  end

  // Transaction FSM with every output registered; async reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_d_q   <= 1'b0;
      streak_q    <= '0;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      i_err_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner_d_q   <= d_wins;
            mem_we_q    <= d_wins ? d_we : 1'b0;
            mem_addr_q  <= d_wins ? d_addr : i_addr;
            mem_wdata_q <= d_wins ? d_wdata : '0;
            mem_req_q   <= 1'b1;
            streak_q    <= streak_d;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_gnt) begin
            mem_req_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_fire) begin
            if (owner_d_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= resp_rdata;
              d_err_q    <= resp_err;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= resp_rdata;
              i_err_q    <= resp_err;
            end
            state_q <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          i_rvalid_q <= 1'b0;
          d_rvalid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // scoreboards
  resp_t i_q[$];
  resp_t d_q[$];
  req_t  g_q[$];
  logic [31:0] i_todo[$];
  req_t        d_todo[$];

  // requester / model control
  bit i_done, d_done, d_abort, stray_n;
  int i_raise_cyc, d_raise_cyc, last_i_cyc, last_d_cyc;
  int m_gdly, m_lat;
  bit m_drop;

  mem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIM(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d miscompares=%0d", vectors, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fetch requester: holds i_req until its rvalid, then takes the next queued address
  initial begin
    i_req = 1'b0;
    i_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (i_done) begin i_done = 0; i_req = 1'b0; end
      if (!i_req && reset_n && i_todo.size() > 0) begin
        i_addr = i_todo.pop_front();
        i_req = 1'b1;
        i_raise_cyc = cyc;
      end
    end
  end

  // data requester: same handshake, abortable across a reset
  initial begin
    req_t r;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (d_done) begin d_done = 0; d_req = 1'b0; end
      if (d_abort) begin d_abort = 0; d_req = 1'b0; end
      if (!d_req && reset_n && d_todo.size() > 0) begin
        r = d_todo.pop_front();
        d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
        d_req = 1'b1;
        d_raise_cyc = cyc;
      end
    end
  end

  // memory model: grant after m_gdly cycles, respond m_lat cycles after grant unless m_drop
  initial begin
    int wcnt, rcnt;
    logic [31:0] r_addr;
    logic r_we;
    wcnt = 0; rcnt = 0; r_addr = '0; r_we = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!reset_n) begin
        wcnt = 0; rcnt = 0;
      end else begin
        if (stray_n) begin
          stray_n = 0;
          mem_rvalid = 1'b1;
          mem_rdata = 32'hBAD0_BAD0;
        end
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = r_we ? 32'hFFFF_FFFF : data_for(r_addr);
          end
        end
        if (mem_req) begin
          if (wcnt >= m_gdly) begin
            mem_gnt = 1'b1;
            wcnt = 0;
            r_addr = mem_addr;
            r_we = mem_we;
            if (!m_drop) rcnt = m_lat;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // output monitor: compare responses and accepted memory requests against the scoreboards
  always @(negedge clk) begin
    resp_t e;
    req_t g;
    if (reset_n) begin
      if (i_rvalid) begin
        chk("i_rvalid_expected", 64'(i_q.size() > 0), 64'd1);
        if (i_q.size() > 0) begin
          e = i_q.pop_front();
          chk("i_rdata", 64'(i_rdata), 64'(e.rdata));
          chk("i_err", 64'(i_err), 64'(e.err));
        end
        last_i_cyc = cyc;
        i_done = 1;
      end
      if (d_rvalid) begin
        chk("d_rvalid_expected", 64'(d_q.size() > 0), 64'd1);
        if (d_q.size() > 0) begin
          e = d_q.pop_front();
          chk("d_rdata", 64'(d_rdata), 64'(e.rdata));
          chk("d_err", 64'(d_err), 64'(e.err));
        end
        last_d_cyc = cyc;
        d_done = 1;
      end
      if (mem_req && mem_gnt) begin
        chk("gnt_expected", 64'(g_q.size() > 0), 64'd1);
        if (g_q.size() > 0) begin
          g = g_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(g.addr));
          chk("mem_we", 64'(mem_we), 64'(g.we));
          if (g.we) chk("mem_wdata", 64'(mem_wdata), 64'(g.wdata));
        end
      end
    end
  end

  task automatic exp_gnt(input logic we, input logic [31:0] a, input logic [31:0] wd);
    req_t g;
    g.we = we; g.addr = a; g.wdata = wd;
    g_q.push_back(g);
  endtask

  task automatic req_i(input logic [31:0] a, input logic [31:0] rd, input logic err);
    resp_t e;
    e.rdata = rd; e.err = err;
    i_q.push_back(e);
    i_todo.push_back(a);
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err);
    resp_t e;
    req_t r;
    e.rdata = rd; e.err = err;
    r.we = we; r.addr = a; r.wdata = wd;
    d_q.push_back(e);
    d_todo.push_back(r);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((i_q.size() + d_q.size() + g_q.size() + i_todo.size() + d_todo.size()) > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_rvalid"}, 64'(i_rvalid), 64'd0);
    chk({tag, "_i_rdata"}, 64'(i_rdata), 64'd0);
    chk({tag, "_i_err"}, 64'(i_err), 64'd0);
    chk({tag, "_d_rvalid"}, 64'(d_rvalid), 64'd0);
    chk({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    chk({tag, "_d_err"}, 64'(d_err), 64'd0);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    m_gdly = 0; m_lat = 2; m_drop = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: lone fetch, grant immediate, response two cycles after grant
    m_gdly = 0; m_lat = 2;
    exp_gnt(1'b0, 32'h100, 32'h0);
    req_i(32'h100, 32'hDEAD_BEEF, 1'b0);
    drain("s1_done", 100);
    chk("s1_latency", 64'(last_i_cyc - i_raise_cyc), 64'd4);

    // 2: simultaneous requests, data served first
    @(negedge clk);
    m_gdly = 0; m_lat = 1;
    exp_gnt(1'b0, 32'h200, 32'h0);
    exp_gnt(1'b0, 32'h100, 32'h0);
    req_d(1'b0, 32'h200, 32'h0, data_for(32'h200), 1'b0);
    req_i(32'h100, 32'hDEAD_BEEF, 1'b0);
    drain("s2_done", 100);

    // 3: sustained contention with STARVE_LIM=2 gives D,D,I,D,D,I
    @(negedge clk);
    m_gdly = 1; m_lat = 1;
    exp_gnt(1'b0, 32'h300, 32'h0);
    exp_gnt(1'b0, 32'h304, 32'h0);
    exp_gnt(1'b0, 32'h110, 32'h0);
    exp_gnt(1'b0, 32'h308, 32'h0);
    exp_gnt(1'b0, 32'h30C, 32'h0);
    exp_gnt(1'b0, 32'h114, 32'h0);
    for (int k = 0; k < 4; k++) req_d(1'b0, 32'h300 + 32'(4 * k), 32'h0, data_for(32'h300 + 32'(4 * k)), 1'b0);
    req_i(32'h110, data_for(32'h110), 1'b0);
    req_i(32'h114, data_for(32'h114), 1'b0);
    drain("s3_done", 300);

    // 4: data write with delayed grant; ack returns rdata 0 despite junk on mem_rdata
    @(negedge clk);
    m_gdly = 2; m_lat = 3;
    exp_gnt(1'b1, 32'h40, 32'h1234_5678);
    req_d(1'b1, 32'h40, 32'h1234_5678, 32'h0, 1'b0);
    drain("s4_done", 100);

    // 5: data read that never completes -> watchdog error after 8 WAIT cycles
    @(negedge clk);
    m_gdly = 0; m_drop = 1;
    exp_gnt(1'b0, 32'h80, 32'h0);
    req_d(1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
    drain("s5_done", 100);
    chk("s5_latency", 64'(last_d_cyc - d_raise_cyc), 64'd10);
    m_drop = 0;
    @(negedge clk);
    stray_n = 1;
    repeat (4) @(negedge clk);
    chk("s5_d_err_hold", 64'(d_err), 64'd1);

    // 6: reset asserted mid-WAIT clears everything immediately; fresh fetch afterwards
    m_drop = 1; m_gdly = 0;
    exp_gnt(1'b0, 32'h90, 32'h0);
    d_todo.push_back('{we: 1'b0, addr: 32'h90, wdata: 32'h0});
    @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    chk("s6_pre_reset_addr", 64'(mem_addr), 64'h90);
    reset_n = 1'b0;
    #1;
    chk_all_zero("s6_reset");
    d_abort = 1;
    m_drop = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stray_n = 1;
    repeat (3) @(negedge clk);
    m_lat = 2;
    exp_gnt(1'b0, 32'h100, 32'h0);
    req_i(32'h100, 32'hDEAD_BEEF, 1'b0);
    drain("s6_done", 100);
    chk("s6_latency", 64'(last_i_cyc - i_raise_cyc), 64'd4);
    chk("s6_d_rvalid_idle", 64'(d_rvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
